// File: rtl/card_punch.sv
// DMA card punch: reads a block of memory words through the shared arbiter and
// streams them byte-serially to a sink. Optional trailing checksum byte: CARD_PUNCH_CHECKSUM_EN.
module card_punch #(
  parameter int unsigned MAX_WORDS = 20,
  parameter int unsigned ADDR_W    = 17
) (
  input  logic              reset,
  input  logic              clock,
  output logic              running,
  input  logic              active,
  input  logic [31:0]       mem_data_in,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_out,
  output logic [3:0]        wr_en,
  input  logic              sio,
  input  logic              tio,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       word_count,
  output logic [3:0]        cc,
  output logic [7:0]        punch_data,
  output logic              punch_valid,
  input  logic              punch_ready
);
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef CARD_PUNCH_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM  = 3'd4;
  logic [7:0] csum_q, csum_d;
`endif

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [23:0]       shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              running_d, valid_d;
  logic              overrun_q, overrun_d, rejected_q, rejected_d, done_q, done_d;
  logic [ADDR_W-1:0] address_d;
  logic [7:0]        punch_data_d;
  logic              handshake;
  logic              unused_tio;

  // The device never writes memory; tio only samples status, which cc always shows.
  assign data_out   = '0;
  assign wr_en      = '0;
  assign unused_tio = tio;
  assign cc         = {running, overrun_q, rejected_q, done_q};
  assign handshake  = punch_valid & punch_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    running_d    = running;
    valid_d      = punch_valid;
    address_d    = address;
    punch_data_d = punch_data;
    overrun_d    = overrun_q;
    rejected_d   = rejected_q;
    done_d       = done_q;
`ifdef CARD_PUNCH_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if (sio && state_q != ST_IDLE) rejected_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (sio) begin
          overrun_d   = 1'b0;
          rejected_d  = 1'b0;
          done_d      = 1'b0;
          address_d   = start_addr;
          remaining_d = word_count;
`ifdef CARD_PUNCH_CHECKSUM_EN
          csum_d      = 8'h00;
`endif
          if (word_count > CNT_W'(MAX_WORDS)) begin
            overrun_d = 1'b1;
          end else if (word_count == '0) begin
`ifdef CARD_PUNCH_CHECKSUM_EN
            state_d      = ST_CSUM;
            valid_d      = 1'b1;
            punch_data_d = 8'h00;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d   = ST_FETCH;
            running_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (active) begin
          punch_data_d = mem_data_in[31:24];
          shift_d      = mem_data_in[23:0];
          valid_d      = 1'b1;
          byte_idx_d   = 2'd0;
          address_d    = address + ADDR_W'(1);
          remaining_d  = remaining_q - CNT_W'(1);
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (handshake) begin
`ifdef CARD_PUNCH_CHECKSUM_EN
          csum_d = csum_q + punch_data;
`endif
          if (byte_idx_q != 2'd3) begin
            byte_idx_d   = byte_idx_q + 2'd1;
            punch_data_d = shift_q[23:16];
            shift_d      = {shift_q[15:0], 8'h00};
          end else if (remaining_q != '0) begin
            valid_d = 1'b0;
            state_d = ST_FETCH;
          end else begin
`ifdef CARD_PUNCH_CHECKSUM_EN
            punch_data_d = csum_q + punch_data;
            state_d      = ST_CSUM;
`else
            valid_d   = 1'b0;
            running_d = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_DONE;
`endif
          end
        end
      end
`ifdef CARD_PUNCH_CHECKSUM_EN
      ST_CSUM: begin
        if (handshake) begin
          valid_d   = 1'b0;
          running_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        running_d = 1'b0;
        valid_d   = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any buffered word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      running     <= 1'b0;
      punch_valid <= 1'b0;
      address     <= '0;
      punch_data  <= '0;
      overrun_q   <= 1'b0;
      rejected_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef CARD_PUNCH_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      running     <= running_d;
      punch_valid <= valid_d;
      address     <= address_d;
      punch_data  <= punch_data_d;
      overrun_q   <= overrun_d;
      rejected_q  <= rejected_d;
      done_q      <= done_d;
`ifdef CARD_PUNCH_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_card_punch.sv
// Scoreboard bench for card_punch: expected byte stream is built from a memory
// model when sio is issued; a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_card_punch;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned MEM_WORDS = 1 << ADDR_W;

  logic              reset, clock, running, active, sio, tio, punch_valid, punch_ready;
  logic [31:0]       mem_data_in, data_out;
  logic [ADDR_W-1:0] address, start_addr;
  logic [3:0]        wr_en, cc;
  logic [15:0]       word_count;
  logic [7:0]        punch_data;

  logic [31:0] mem [MEM_WORDS];
  logic [7:0]  exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          popped = 0;
  int          rdy_mode = 0;
  int          act_mode = 0;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        saw_running = 1'b0;

  card_punch dut (
    .reset(reset), .clock(clock), .running(running), .active(active),
    .mem_data_in(mem_data_in), .address(address), .data_out(data_out), .wr_en(wr_en),
    .sio(sio), .tio(tio), .start_addr(start_addr), .word_count(word_count), .cc(cc),
    .punch_data(punch_data), .punch_valid(punch_valid), .punch_ready(punch_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_data_in = mem[address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sink readiness and arbiter grants, changed just after each edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       punch_ready = 1'b1;
      1:       punch_ready = (cyc % 3 == 0);
      default: punch_ready = ($urandom_range(0, 1) == 1);
    endcase
    active = (act_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
  end

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (running) saw_running = 1'b1;
      if (prev_stall) begin
        check("stall_valid", 32'(punch_valid), 32'd1);
        check("stall_data", 32'(punch_data), 32'(prev_data));
      end
      if (punch_valid && punch_ready) begin
        check("wr_en", 32'(wr_en), 32'd0);
        check("data_out", data_out, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h, expected none", punch_data);
        end else begin
          check("byte", 32'(punch_data), 32'(exp_q.pop_front()));
        end
        popped++;
      end
      prev_stall = punch_valid && !punch_ready;
      prev_data  = punch_data;
    end
  end

  // Reference model: words read in address order with wrap, bytes MSB first.
  task automatic push_expected(input logic [ADDR_W-1:0] a, input int n);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [7:0]  b;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = mem[(int'(a) + i) % MEM_WORDS];
      for (int k = 0; k < 4; k++) begin
        b = w[31 - 8*k -: 8];
        exp_q.push_back(b);
        sum = sum + b;
      end
    end
`ifdef CARD_PUNCH_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic issue_sio(input logic [ADDR_W-1:0] a, input logic [15:0] n);
    @(posedge clock); #1;
    sio = 1'b1; start_addr = a; word_count = n;
    @(posedge clock); #1;
    sio = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (cc[0]) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL done_timeout: got cc=%b, expected done within %0d cycles", cc, budget);
    end
  endtask

  task automatic run_xfer(input logic [ADDR_W-1:0] a, input int n, input logic [3:0] exp_cc);
    push_expected(a, n);
    saw_running = 1'b0;
    issue_sio(a, 16'(n));
    @(negedge clock);
    check("running_start", 32'(running), 32'(n > 0));
    wait_done(4000);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("cc_end", 32'(cc), 32'(exp_cc));
    check("running_end", 32'(running), 32'd0);
    check("saw_running", 32'(saw_running), 32'(n > 0));
    exp_q.delete();
  endtask

  initial begin
    int base;
    reset = 1'b1; sio = 1'b0; tio = 1'b0; start_addr = '0; word_count = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
    mem[32'h40] = 32'h11223344;
    mem[32'h41] = 32'h55667788;

    #12;
    check("rst_running", 32'(running), 32'd0);
    check("rst_valid", 32'(punch_valid), 32'd0);
    check("rst_cc", 32'(cc), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data", 32'(punch_data), 32'd0);
    #11 reset = 1'b0;

    // basic stream, then with a slow sink
    run_xfer(17'h40, 2, 4'b0001);
    rdy_mode = 1;
    run_xfer(17'h40, 2, 4'b0001);

    // sio during a transfer is rejected and does not disturb the stream
    push_expected(17'h40, 2);
    issue_sio(17'h40, 16'd2);
    repeat (3) @(posedge clock);
    issue_sio(17'h80, 16'd5);
    @(negedge clock);
    check("reject_flag", 32'(cc[1]), 32'd1);
    check("reject_running", 32'(running), 32'd1);
    wait_done(4000);
    check("reject_queue", 32'(exp_q.size()), 32'd0);
    check("reject_cc", 32'(cc), 32'b0011);
    exp_q.delete();

    // zero count, then overrun; tio must not change status
    rdy_mode = 0;
    run_xfer(17'h40, 0, 4'b0001);
    saw_running = 1'b0;
    issue_sio(17'h40, 16'd21);
    repeat (5) @(negedge clock);
    check("overrun_cc", 32'(cc), 32'b0100);
    check("overrun_running", 32'(saw_running), 32'd0);
    @(posedge clock); #1 tio = 1'b1;
    @(posedge clock); #1 tio = 1'b0;
    @(negedge clock);
    check("tio_cc", 32'(cc), 32'b0100);

    // address wrap with random sink and sparse grants
    rdy_mode = 2; act_mode = 1;
    run_xfer(17'h1FFFF, 2, 4'b0001);

    // reset after the third byte, then a clean restart
    rdy_mode = 0; act_mode = 0;
    push_expected(17'h40, 2);
    base = popped;
    issue_sio(17'h40, 16'd2);
    for (int i = 0; i < 200 && popped < base + 3; i++) @(negedge clock);
    check("bytes_before_reset", 32'(popped - base), 32'd3);
    @(posedge clock); #2 reset = 1'b1;
    #1;
    check("mid_rst_running", 32'(running), 32'd0);
    check("mid_rst_valid", 32'(punch_valid), 32'd0);
    check("mid_rst_cc", 32'(cc), 32'd0);
    exp_q.delete();
    @(posedge clock); #3 reset = 1'b0;
    run_xfer(17'h40, 2, 4'b0001);

    // random transfers
    for (int t = 0; t < 10; t++) begin
      rdy_mode = $urandom_range(0, 2);
      act_mode = $urandom_range(0, 1);
      run_xfer(ADDR_W'($urandom), $urandom_range(0, 20), 4'b0001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
